// File: rtl/if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch : RV32I fetch stage, byte-serial instruction assembly       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_if,
  input  logic        branch_enable,
  input  logic [31:0] branch_addr,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_rd_en,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [2:0] {
    ST_B0   = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_B4   = 3'd4,
    ST_DONE = 3'd5
  } st_t;

  st_t         r_st;
  st_t         w_st_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        w_out_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= ST_B0;
      r_pc      <= RESET_PC;
      r_inst    <= 32'd0;
      r_if_pc   <= 32'd0;
      r_if_inst <= 32'd0;
    end else begin
      r_st   <= w_st_nxt;
      r_pc   <= w_pc_nxt;
      r_inst <= w_inst_nxt;
      if (w_out_load) begin
        r_if_pc   <= r_pc;
        r_if_inst <= w_inst_nxt;
      end
    end
  end

  // Byte k-1 arrives in state Bk, one cycle after its address was issued.
  always_comb begin
    w_st_nxt   = r_st;
    w_pc_nxt   = r_pc;
    w_inst_nxt = r_inst;
    w_out_load = 1'b0;
    if (!rdy) begin
      w_st_nxt = r_st;
    end else if (branch_enable) begin
      w_st_nxt   = ST_B0;
      w_pc_nxt   = branch_addr;
      w_inst_nxt = 32'd0;
    end else begin
      case (r_st)
        ST_B0: w_st_nxt = ST_B1;
        ST_B1: begin
          w_inst_nxt[7:0] = mem_din;
          w_st_nxt        = ST_B2;
        end
        ST_B2: begin
          w_inst_nxt[15:8] = mem_din;
          w_st_nxt         = ST_B3;
        end
        ST_B3: begin
          w_inst_nxt[23:16] = mem_din;
          w_st_nxt          = ST_B4;
        end
        ST_B4: begin
          w_inst_nxt[31:24] = mem_din;
          w_st_nxt          = ST_DONE;
          w_out_load        = 1'b1;
        end
        ST_DONE: begin
          if (!stall_if) begin
            w_pc_nxt = r_pc + 32'd4;
            w_st_nxt = ST_B0;
          end
        end
        default: w_st_nxt = ST_B0;
      endcase
    end
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_a     = r_pc;
    case (r_st)
      ST_B0, ST_B1, ST_B2, ST_B3: begin
        mem_rd_en = 1'b1;
        mem_a     = r_pc + {30'd0, r_st[1:0]};
      end
      default: begin
        mem_rd_en = 1'b0;
        mem_a     = r_pc;
      end
    endcase
  end

  assign if_valid = (r_st == ST_DONE);
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_fetch : scoreboard bench for the byte-serial fetch stage       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_if_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        stall_if = 1'b0;
  logic        branch_enable = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [7:0]  mem_din = 8'd0;
  logic [31:0] mem_a;
  logic        mem_rd_en;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  if_fetch #(.RESET_PC(C_RESET_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_if(stall_if),
    .branch_enable(branch_enable), .branch_addr(branch_addr),
    .mem_din(mem_din), .mem_a(mem_a), .mem_rd_en(mem_rd_en),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'hA0;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  // Synchronous read memory, frozen together with the pipeline when rdy is low.
  always @(posedge clk) if (rdy) mem_din <= mbyte(mem_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!if_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    n_vec++; if (if_inst !== 32'd0) begin n_err++; $display("FAIL rst_inst got=%h exp=0", if_inst); end
    n_vec++; if (if_pc !== 32'd0) begin n_err++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
    n_vec++; if (mem_rd_en !== 1'b1 || mem_a !== C_RESET_PC) begin
      n_err++; $display("FAIL rst_mem got=%b/%h exp=1/%h", mem_rd_en, mem_a, C_RESET_PC); end
    rst = 1'b0;
    sb.push_back('{pc: C_RESET_PC, inst: word(C_RESET_PC)});
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (mem_rd_en !== 1'b1 || mem_a !== C_RESET_PC + k) begin
        n_err++; $display("FAIL fetch_addr%0d got=%b/%h exp=1/%h", k, mem_rd_en, mem_a, C_RESET_PC + k); end
      tick();
    end
    n_vec++; if (mem_rd_en !== 1'b0 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL b4_idle got=%b/%b exp=0/0", mem_rd_en, if_valid); end
    tick();
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL t5_valid got=%b exp=1", if_valid); end
    e = sb.pop_front();
    n_vec++; if (if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL reset_word got=%h/%h exp=%h/%h", if_pc, if_inst, e.pc, e.inst); end
    tick();
    n_vec++; if (mem_a !== C_RESET_PC + 32'd4 || mem_rd_en !== 1'b1) begin
      n_err++; $display("FAIL t6_next got=%h exp=%h", mem_a, C_RESET_PC + 32'd4); end
    n = 0;
  endtask

  task automatic test_stall();
    exp_t        e;
    int          n;
    logic [31:0] pc0;
    pc0 = mem_a;
    sb.push_back('{pc: pc0, inst: word(pc0)});
    stall_if = 1'b1;
    wait_valid(n);
    n_vec++; if (n !== 5) begin n_err++; $display("FAIL stall_latency got=%0d exp=5", n); end
    e = sb.pop_front();
    n_vec++; if (if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL stall_word got=%h/%h exp=%h/%h", if_pc, if_inst, e.pc, e.inst); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst || mem_rd_en !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/%h/%h/0", k, if_valid, if_pc, if_inst, mem_rd_en, e.pc, e.inst); end
    end
    stall_if = 1'b0;
    tick();
    n_vec++; if (if_valid !== 1'b0 || mem_a !== pc0 + 32'd4) begin
      n_err++; $display("FAIL stall_release got=%b/%h exp=0/%h", if_valid, mem_a, pc0 + 32'd4); end
  endtask

  task automatic test_redirect_mid();
    exp_t        e;
    int          n;
    logic [31:0] pc0;
    pc0 = mem_a;
    tick(); tick();
    n_vec++; if (mem_a !== pc0 + 32'd2) begin n_err++; $display("FAIL mid_b2 got=%h exp=%h", mem_a, pc0 + 32'd2); end
    branch_enable = 1'b1; branch_addr = 32'h0000_0100;
    tick();
    branch_enable = 1'b0;
    n_vec++; if (mem_a !== 32'h100 || mem_rd_en !== 1'b1) begin
      n_err++; $display("FAIL mid_target got=%h exp=00000100", mem_a); end
    sb.push_back('{pc: 32'h100, inst: word(32'h100)});
    wait_valid(n);
    n_vec++; if (n !== 5) begin n_err++; $display("FAIL mid_latency got=%0d exp=5", n); end
    e = sb.pop_front();
    n_vec++; if (if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL mid_word got=%h/%h exp=%h/%h", if_pc, if_inst, e.pc, e.inst); end
  endtask

  task automatic test_redirect_done();
    exp_t e;
    int   n;
    // In DONE for 0x100: redirect while accepting beats pc+4.
    branch_enable = 1'b1; branch_addr = 32'h0000_0200; stall_if = 1'b0;
    tick();
    branch_enable = 1'b0;
    n_vec++; if (mem_a !== 32'h200) begin n_err++; $display("FAIL done_redirect got=%h exp=00000200", mem_a); end
    sb.push_back('{pc: 32'h200, inst: word(32'h200)});
    stall_if = 1'b1;
    wait_valid(n);
    e = sb.pop_front();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL done_word got=%b/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, e.pc, e.inst); end
    branch_enable = 1'b1; branch_addr = 32'h0000_0300;
    tick();
    branch_enable = 1'b0; stall_if = 1'b0;
    n_vec++; if (if_valid !== 1'b0 || mem_a !== 32'h300) begin
      n_err++; $display("FAIL stall_drop got=%b/%h exp=0/00000300", if_valid, mem_a); end
    sb.push_back('{pc: 32'h300, inst: word(32'h300)});
    wait_valid(n);
    e = sb.pop_front();
    n_vec++; if (n !== 5 || if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL drop_word got=%0d/%h/%h exp=5/%h/%h", n, if_pc, if_inst, e.pc, e.inst); end
    tick();
  endtask

  task automatic test_rdy_gap();
    exp_t        e;
    int          n;
    logic [31:0] pc0;
    pc0 = mem_a;
    sb.push_back('{pc: pc0, inst: word(pc0)});
    repeat (3) tick();
    n_vec++; if (mem_a !== pc0 + 32'd3) begin n_err++; $display("FAIL gap_b3 got=%h exp=%h", mem_a, pc0 + 32'd3); end
    rdy = 1'b0;
    repeat (2) tick();
    n_vec++; if (mem_a !== pc0 + 32'd3 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL gap_hold got=%h/%b exp=%h/0", mem_a, if_valid, pc0 + 32'd3); end
    rdy = 1'b1;
    wait_valid(n);
    n_vec++; if (n + 5 !== 7) begin n_err++; $display("FAIL gap_latency got=%0d exp=7", n + 5); end
    e = sb.pop_front();
    n_vec++; if (if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL gap_word got=%h/%h exp=%h/%h", if_pc, if_inst, e.pc, e.inst); end
    tick();
  endtask

  task automatic test_reset_mid_and_wrap();
    exp_t e;
    int   n;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (mem_a !== C_RESET_PC || if_valid !== 1'b0 || if_inst !== 32'd0 || if_pc !== 32'd0) begin
      n_err++; $display("FAIL rst_mid got=%h/%b/%h/%h exp=%h/0/0/0", mem_a, if_valid, if_inst, if_pc, C_RESET_PC); end
    sb.push_back('{pc: C_RESET_PC, inst: word(C_RESET_PC)});
    wait_valid(n);
    e = sb.pop_front();
    n_vec++; if (n !== 5 || if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL rst_mid_word got=%0d/%h/%h exp=5/%h/%h", n, if_pc, if_inst, e.pc, e.inst); end
    branch_enable = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_enable = 1'b0;
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: word(32'hFFFF_FFFC)});
    wait_valid(n);
    e = sb.pop_front();
    n_vec++; if (n !== 5 || if_pc !== e.pc || if_inst !== e.inst) begin
      n_err++; $display("FAIL wrap_word got=%0d/%h/%h exp=5/%h/%h", n, if_pc, if_inst, e.pc, e.inst); end
    tick();
    n_vec++; if (mem_a !== 32'd0 || mem_rd_en !== 1'b1) begin
      n_err++; $display("FAIL wrap_next got=%h exp=00000000", mem_a); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_mid();
    test_redirect_done();
    test_rdy_gap();
    test_reset_mid_and_wrap();
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
